// File: rtl/div_unit.sv
// 32-bit restoring divider with signed/unsigned modes, annul and divide-by-zero handling.
// Results appear on hi (remainder) and lo (quotient) with a one-cycle done pulse.
module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        signed_div,
   input  logic        annul,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t      state, state_next;
   logic [4:0]  cnt;
   logic [31:0] quo;
   logic [31:0] dvs;
   logic [31:0] rem;
   logic        sign_a, sign_b;

   logic [31:0] abs_a, abs_b;
   logic [32:0] rem_sh;
   logic [31:0] rem_sub;
   logic        fits;
   logic [31:0] quo_next;
   logic [31:0] rem_next;
   logic        take;

   assign take  = start && !annul;
   assign abs_a = (signed_div && a[31]) ? -a : a;
   assign abs_b = (signed_div && b[31]) ? -b : b;

   // One restoring step: the 33-bit shifted remainder never overflows the compare.
   always_comb begin
      rem_sh   = {rem, quo[31]};
      fits     = (rem_sh >= {1'b0, dvs});
      rem_sub  = rem_sh[31:0] - dvs;
      rem_next = fits ? rem_sub : rem_sh[31:0];
      quo_next = {quo[30:0], fits};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (take) state_next = (b == 32'd0) ? DONE : CALC;
         CALC: begin
            if (annul)              state_next = IDLE;
            else if (cnt == 5'd31)  state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt    <= '0;
         quo    <= '0;
         dvs    <= '0;
         rem    <= '0;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (take) begin
                  if (b == 32'd0) begin
                     lo <= 32'hFFFF_FFFF;
                     hi <= a;
                  end else begin
                     quo    <= abs_a;
                     dvs    <= abs_b;
                     rem    <= '0;
                     sign_a <= signed_div && a[31];
                     sign_b <= signed_div && b[31];
                     cnt    <= '0;
                  end
               end
            end
            CALC: begin
               if (!annul) begin
                  quo <= quo_next;
                  rem <= rem_next;
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd31) begin
                     lo <= (sign_a ^ sign_b) ? -quo_next : quo_next;
                     hi <= sign_a ? -rem_next : rem_next;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vectors, randomized divisions against
// an arithmetic reference, annul, ignored start and asynchronous reset.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        signed_div = 1'b0;
   logic        annul = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done;
   logic [31:0] hi, lo;

   int tests_run = 0;
   int tests_failed = 0;
   int cyc = 0;

   div_unit dut (
      .clk(clk), .rst(rst), .start(start), .signed_div(signed_div), .annul(annul),
      .a(a), .b(b), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer division; 64-bit signed math avoids the MIN/-1 overflow.
   function automatic void ref_div(input logic [31:0] x, input logic [31:0] y, input bit s,
                                   output logic [31:0] q, output logic [31:0] r);
      longint sx, sy;
      if (y == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = x;
      end else if (s) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
         q = 32'(sx / sy);
         r = 32'(sx % sy);
      end else begin
         q = x / y;
         r = x % y;
      end
   endfunction

   // Issue one start in the next cycle and wait (bounded) for done.
   // lat is cycles from the start cycle to the cycle where done was seen.
   task automatic drive_div(input logic [31:0] da, input logic [31:0] db, input bit ds,
                            output int lat, output bit busy_ok);
      int n;
      @(posedge clk); #1;
      a = da; b = db; signed_div = ds; start = 1'b1;
      n = cyc;
      busy_ok = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done && (cyc - n) < 40) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
      end
      if (!busy) busy_ok = 1'b0;
      lat = cyc - n;
   endtask

   task automatic check_div(input string name, input logic [31:0] da, input logic [31:0] db,
                            input bit ds);
      int lat; bit busy_ok; logic [31:0] eq, er; int exp_lat;
      ref_div(da, db, ds, eq, er);
      exp_lat = (db == 32'd0) ? 1 : 33;
      drive_div(da, db, ds, lat, busy_ok);
      tests_run++;
      if (lat !== exp_lat) begin
         tests_failed++;
         $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      end
      tests_run++;
      if (lo !== eq) begin
         tests_failed++;
         $display("FAIL %s lo a=%h b=%h s=%0d: got %h expected %h", name, da, db, ds, lo, eq);
      end
      tests_run++;
      if (hi !== er) begin
         tests_failed++;
         $display("FAIL %s hi a=%h b=%h s=%0d: got %h expected %h", name, da, db, ds, hi, er);
      end
      tests_run++;
      if (busy_ok !== 1'b1) begin
         tests_failed++;
         $display("FAIL %s busy: got a low cycle expected busy high throughout", name);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({busy, done} !== 2'b00) begin
         tests_failed++;
         $display("FAIL %s after_done busy/done: got %b expected 00", name, {busy, done});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      tests_run++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         tests_failed++;
         $display("FAIL reset_values: got busy=%b done=%b hi=%h lo=%h expected all 0",
                  busy, done, hi, lo);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release busy: got %b expected 0", busy);
      end
   endtask

   task automatic test_directed();
      check_div("unsigned_ffffffff_10", 32'hFFFF_FFFF, 32'h10, 1'b0);
      tests_run++;
      if ({lo, hi} !== {32'h0FFF_FFFF, 32'hF}) begin
         tests_failed++;
         $display("FAIL vec_unsigned: got lo=%h hi=%h expected 0fffffff/0000000f", lo, hi);
      end
      check_div("signed_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
      tests_run++;
      if ({lo, hi} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin
         tests_failed++;
         $display("FAIL vec_signed: got lo=%h hi=%h expected fffffffd/ffffffff", lo, hi);
      end
      check_div("signed_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
      tests_run++;
      if ({lo, hi} !== {32'h8000_0000, 32'h0}) begin
         tests_failed++;
         $display("FAIL vec_min_m1: got lo=%h hi=%h expected 80000000/00000000", lo, hi);
      end
      check_div("div_zero", 32'h1234, 32'd0, 1'b0);
      check_div("div_zero_signed", 32'h8765_4321, 32'd0, 1'b1);
      check_div("unsigned_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] ra, rb;
      bit rs;
      for (int i = 0; i < 30; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'd0;
            1:       rb = 32'($urandom_range(1, 20));
            2:       rb = -32'($urandom_range(1, 20));
            default: rb = $urandom;
         endcase
         rs = 1'($urandom_range(0, 1));
         check_div("random", ra, rb, rs);
      end
   endtask

   task automatic test_annul();
      logic [31:0] prev_hi, prev_lo;
      int lat; bit busy_ok; bit saw_done;
      prev_hi = hi; prev_lo = lo;
      // start with annul held: must be ignored
      @(posedge clk); #1;
      a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1; annul = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; annul = 1'b0;
      tests_run++;
      if (busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL annul_idle_start: got busy=%b expected 0", busy);
      end
      // start at N, annul at N+10, IDLE at N+11
      a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      saw_done = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0;
      tests_run++;
      if ({busy, done, saw_done} !== 3'b000) begin
         tests_failed++;
         $display("FAIL annul_calc state: got busy=%b done=%b early_done=%b expected 000",
                  busy, done, saw_done);
      end
      tests_run++;
      if ({hi, lo} !== {prev_hi, prev_lo}) begin
         tests_failed++;
         $display("FAIL annul_calc hold: got hi=%h lo=%h expected %h/%h", hi, lo, prev_hi, prev_lo);
      end
      drive_div(32'd100, 32'd7, 1'b0, lat, busy_ok);
      tests_run++;
      if ({lat, lo, hi} !== {33, 32'd14, 32'd2}) begin
         tests_failed++;
         $display("FAIL annul_restart: got lat=%0d lo=%0d hi=%0d expected 33/14/2", lat, lo, hi);
      end
      // annul during the DONE cycle has no effect on the results
      annul = 1'b1;
      @(posedge clk); #1;
      annul = 1'b0;
      tests_run++;
      if ({busy, done, lo, hi} !== {1'b0, 1'b0, 32'd14, 32'd2}) begin
         tests_failed++;
         $display("FAIL annul_done: got busy=%b done=%b lo=%0d hi=%0d expected 0/0/14/2",
                  busy, done, lo, hi);
      end
   endtask

   task automatic test_ignored_start();
      int n; bit saw_done;
      @(posedge clk); #1;
      a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
      n = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      a = 32'd5; b = 32'd1; signed_div = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (!done && (cyc - n) < 40) begin
         @(posedge clk); #1;
      end
      tests_run++;
      if ({cyc - n, lo, hi} !== {33, 32'd333, 32'd1}) begin
         tests_failed++;
         $display("FAIL ignored_start: got lat=%0d lo=%0d hi=%0d expected 33/333/1",
                  cyc - n, lo, hi);
      end
      // rst pulse mid-CALC clears everything at once
      @(posedge clk); #1;
      a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (19) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      tests_run++;
      if ({busy, done, hi, lo} !== 66'd0) begin
         tests_failed++;
         $display("FAIL reset_mid_calc: got busy=%b done=%b hi=%h lo=%h expected all 0",
                  busy, done, hi, lo);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (done || busy) saw_done = 1'b1;
      end
      tests_run++;
      if (saw_done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_no_done: got activity after reset expected idle");
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         check_div("back_to_back", $urandom, 32'($urandom_range(1, 1000)), 1'(i % 2));
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_annul();
      test_ignored_start();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 32-bit operands.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-high.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 signed_div  input  1  1 = signed (two's complement), 0 = unsigned; sampled with start.
REQ-006 annul  input  1  cancel an in-flight division (pipeline flush).
REQ-007 a  input  32  dividend (regfile rd1 value); sampled with start.
REQ-008 b  input  32  divisor (regfile rd2 value); sampled with start.
REQ-009 busy  output  1  high whenever state is not IDLE; pipeline stalls on it.
REQ-010 done  output  1  one-cycle pulse; hi/lo are valid from this cycle.
REQ-011 hi  output  32  remainder register.
REQ-012 lo  output  32  quotient register.

Function
REQ-013 The block SHALL implement states IDLE, CALC and DONE, encoded in a registered state variable.
REQ-014 IDLE with start=1, annul=0 and b!=0: capture operands and go to CALC.
- Signed mode: capture |a|, |b|, sign(a), sign(b).
- Unsigned mode: capture raw values, signs cleared.
- Clear the 5-bit iteration counter.
REQ-015 IDLE with start=1, annul=0 and b==0: go directly to DONE, loading lo=32'hFFFFFFFF and hi=a (raw a, either mode).
REQ-016 IDLE with start=1 and annul=1: ignore start; remain in IDLE.
REQ-017 CALC: perform one restoring shift-subtract step per cycle, producing one quotient bit MSB-first, for exactly 32 cycles (counter 0..31).
REQ-018 On the edge ending the 32nd CALC cycle, the block SHALL go to DONE and load the sign-corrected results.
- lo = quotient, negated if sign(a)^sign(b).
- hi = remainder, negated if sign(a).
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency: start sampled in cycle N -> done=1 in cycle N+33 (b!=0) or in cycle N+1 (b==0).
REQ-021 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-022 annul=1 in CALC SHALL return the block to IDLE on the next edge with no done pulse and hi/lo unchanged.
REQ-023 annul in DONE SHALL have no effect: done still pulses and hi/lo keep their new values.
REQ-024 hi/lo SHALL hold their values between divisions and change only on entry to DONE.
REQ-025 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (no overflow flag).
REQ-026 Arithmetic SHALL use a 33-bit partial remainder so no step overflows.

Reset
REQ-027 While rst=1, the block SHALL asynchronously force the following values, and SHALL hold them until the first rising edge after rst falls.
- state=IDLE, busy=0, done=0.
- hi=0, lo=0, counter=0.
- Captured operands and signs cleared.
REQ-028 rst asserted mid-CALC or in DONE SHALL abort immediately with no done pulse.

Verification
REQ-029 Unsigned: a=0xFFFFFFFF, b=0x10, start in cycle N -> done in cycle N+33, lo=0x0FFFFFFF, hi=0xF; busy high cycles N+1..N+33.
REQ-030 Signed: a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); also 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 Divide by zero: a=0x1234, b=0 -> done in cycle N+1, lo=0xFFFFFFFF, hi=0x1234.
REQ-032 Annul: start with a=100, b=7, annul at cycle N+10 -> IDLE at N+11, no done, hi/lo keep prior values; a new start at N+12 (a=100, b=7) -> lo=14, hi=2 at N+45.
REQ-033 Ignored start / reset: start with new operands at cycle N+5 of a running division -> original result unaffected; rst pulse at N+20 -> busy, done, hi and lo read 0 immediately, no done afterwards.
